// File: rtl/imm_pkg.sv
// Shared constants and types for the immediate generator pipeline.
package imm_pkg;

   // Default result width.
   localparam int XLEN_DEF = 32;

   // Immediate format selector codes.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;
   localparam logic [2:0] IMM_Z = 3'b101;

   // Occupancy of the two-entry output buffer.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input and output handshake channels of the immediate generator.
interface imm_gen_pipe_if import imm_pkg::*; #(
   parameter int XLEN = XLEN_DEF
);
   logic            in_valid;
   logic            in_ready;
   logic [24:0]     in_instr;
   logic [2:0]      in_imm_src;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic            out_err;

   // Source/sink side (drives instructions, accepts results).
   modport master (
      output in_valid, in_instr, in_imm_src, out_ready,
      input  in_ready, out_valid, out_imm, out_err
   );

   // Block side.
   modport slave (
      input  in_valid, in_instr, in_imm_src, out_ready,
      output in_ready, out_valid, out_imm, out_err
   );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder. in_instr carries instruction bits [31:7],
// so instruction bit k lives at in_instr[k-7]. The immediate is first built
// at 32 bits and then sign-extended to XLEN, which makes the XLEN=32 result
// identical to the 32-bit definitions.
module imm_decode import imm_pkg::*; #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [24:0]     in_instr,
   input  logic [2:0]      in_imm_src,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   logic               sign_s;
   logic signed [31:0] raw_s;

   assign sign_s = in_instr[24];

   // Select the 32-bit immediate layout for the requested format.
   always_comb begin
      raw_s = 32'sd0;
      err   = 1'b0;
      case (in_imm_src)
         IMM_I:   raw_s = {{20{sign_s}}, in_instr[24:13]};
         IMM_S:   raw_s = {{20{sign_s}}, in_instr[24:18], in_instr[4:0]};
         IMM_B:   raw_s = {{20{sign_s}}, in_instr[0], in_instr[23:18],
                           in_instr[4:1], 1'b0};
         IMM_J:   raw_s = {{12{sign_s}}, in_instr[12:5], in_instr[13],
                           in_instr[23:14], 1'b0};
         IMM_U:   raw_s = {in_instr[24:5], 12'h000};
         IMM_Z:   raw_s = {27'd0, in_instr[12:8]};
         default: begin
            raw_s = 32'sd0;
            err   = 1'b1;
         end
      endcase
   end

   assign imm = XLEN'(raw_s);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a one-cycle decode stage and a two-entry skid
// buffer on the output. Results are decoded on the input side and stored
// already formed; in_ready is a flop so it never depends on out_ready.
module imm_gen_pipe import imm_pkg::*; #(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   imm_gen_pipe_if.slave    bus,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [XLEN-1:0]  dec_imm_s;
   logic             dec_err_s;
   logic             acc_s;
   logic             drn_s;

   buf_state_e       state_q,    state_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d;
   logic             main_err_q, main_err_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic             skid_err_q, skid_err_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .in_instr   (bus.in_instr),
      .in_imm_src (bus.in_imm_src),
      .imm        (dec_imm_s),
      .err        (dec_err_s)
   );

   assign acc_s = bus.in_valid & in_ready_q;
   assign drn_s = out_valid_q & bus.out_ready;

   // Buffer next-state, data movement and saturating error count.
   always_comb begin
      state_d    = state_q;
      main_imm_d = main_imm_q;
      main_err_d = main_err_q;
      skid_imm_d = skid_imm_q;
      skid_err_d = skid_err_q;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         BUF_EMPTY: begin
            if (acc_s) begin
               main_imm_d = dec_imm_s;
               main_err_d = dec_err_s;
               state_d    = BUF_ONE;
            end else begin
               state_d    = BUF_EMPTY;
            end
         end
         BUF_ONE: begin
            if (acc_s && drn_s) begin
               main_imm_d = dec_imm_s;
               main_err_d = dec_err_s;
               state_d    = BUF_ONE;
            end else if (acc_s) begin
               skid_imm_d = dec_imm_s;
               skid_err_d = dec_err_s;
               state_d    = BUF_FULL;
            end else if (drn_s) begin
               state_d    = BUF_EMPTY;
            end else begin
               state_d    = BUF_ONE;
            end
         end
         BUF_FULL: begin
            // in_ready is low here, so only a drain can happen.
            if (drn_s) begin
               main_imm_d = skid_imm_q;
               main_err_d = skid_err_q;
               state_d    = BUF_ONE;
            end else begin
               state_d    = BUF_FULL;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
         end
      endcase

      if (acc_s && dec_err_s && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_d = err_cnt_q;
      end

      out_valid_d = (state_d != BUF_EMPTY);
      in_ready_d  = (state_d != BUF_FULL);
   end

   // State and data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= BUF_EMPTY;
         main_imm_q  <= {XLEN{1'b0}};
         main_err_q  <= 1'b0;
         skid_imm_q  <= {XLEN{1'b0}};
         skid_err_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         err_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         main_imm_q  <= main_imm_d;
         main_err_q  <= main_err_d;
         skid_imm_q  <= skid_imm_d;
         skid_err_q  <= skid_err_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = main_imm_q;
   assign bus.out_err   = main_err_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: a 32-bit and a 64-bit instance share identical
// stimulus and are compared against a FIFO reference model whose immediates
// are computed arithmetically from the full 32-bit instruction word.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0] cnt32;
   logic [7:0] cnt64;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [63:0] imm;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   cnt_m = 0;

   imm_gen_pipe_if #(.XLEN(32)) bus32();
   imm_gen_pipe_if #(.XLEN(64)) bus64();

   imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(bus32), .err_cnt(cnt32)
   );
   imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .bus(bus64), .err_cnt(cnt64)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference immediate from the full instruction word, 64-bit wide.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                           input logic [2:0] src,
                                           output logic err);
      longint sx;
      longint v;
      sx  = $signed(ins);
      err = 1'b0;
      case (src)
         3'd0: v = sx >>> 20;
         3'd1: v = ((sx >>> 25) <<< 5) + longint'((ins >> 7) & 32'd31);
         3'd2: v = (ins[31] ? -64'sd4096 : 64'sd0)
                   + longint'(((ins >> 7) & 32'd1) << 11)
                   + longint'(((ins >> 25) & 32'd63) << 5)
                   + longint'(((ins >> 8) & 32'd15) << 1);
         3'd3: v = (ins[31] ? -64'sd1048576 : 64'sd0)
                   + longint'(ins & 32'h000F_F000)
                   + longint'(((ins >> 20) & 32'd1) << 11)
                   + longint'(((ins >> 21) & 32'd1023) << 1);
         3'd4: v = (sx >>> 12) <<< 12;
         3'd5: v = longint'((ins >> 15) & 32'd31);
         default: begin
            v   = 64'sd0;
            err = 1'b1;
         end
      endcase
      return v;
   endfunction

   // One cycle: drive inputs, check outputs against the model, advance model.
   task automatic step(input logic v, input logic [31:0] ins,
                       input logic [2:0] src, input logic ordy);
      logic acc;
      logic drn;
      logic e_err;
      exp_t e;
      bus32.in_valid = v;  bus32.in_instr = ins[31:7];
      bus32.in_imm_src = src; bus32.out_ready = ordy;
      bus64.in_valid = v;  bus64.in_instr = ins[31:7];
      bus64.in_imm_src = src; bus64.out_ready = ordy;
      #1;
      check_val("out_valid", {63'd0, bus32.out_valid}, {63'd0, exp_q.size() != 0});
      check_val("in_ready", {63'd0, bus32.in_ready}, {63'd0, exp_q.size() < 2});
      check_val("out_valid64", {63'd0, bus64.out_valid}, {63'd0, exp_q.size() != 0});
      check_val("err_cnt", {56'd0, cnt32}, 64'(cnt_m));
      check_val("err_cnt64", {56'd0, cnt64}, 64'(cnt_m));
      if (exp_q.size() != 0) begin
         check_val("out_imm32", {32'd0, bus32.out_imm}, {32'd0, exp_q[0].imm[31:0]});
         check_val("out_imm64", bus64.out_imm, exp_q[0].imm);
         check_val("out_err", {63'd0, bus32.out_err}, {63'd0, exp_q[0].err});
      end
      acc = v && (exp_q.size() < 2);
      drn = ordy && (exp_q.size() != 0);
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
         e.imm = ref_imm(ins, src, e_err);
         e.err = e_err;
         exp_q.push_back(e);
         if (e_err && cnt_m < 255) cnt_m++;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      bus32.in_valid = 1'b1; bus64.in_valid = 1'b1;
      bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      cnt_m = 0;
      check_val("rst_valid", {63'd0, bus32.out_valid}, 64'd0);
      check_val("rst_ready", {63'd0, bus32.in_ready}, 64'd1);
      check_val("rst_imm", {32'd0, bus32.out_imm}, 64'd0);
      check_val("rst_err", {63'd0, bus32.out_err}, 64'd0);
      check_val("rst_cnt", {56'd0, cnt32}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_instr = 25'd0;
      bus32.in_imm_src = 3'd0; bus32.out_ready = 1'b0;
      bus64.in_valid = 1'b0; bus64.in_instr = 25'd0;
      bus64.in_imm_src = 3'd0; bus64.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      apply_reset();

      // I-type all-ones.
      step(1'b1, 32'hFFF0_0000, 3'd0, 1'b1);
      check_val("i_type", {32'd0, bus32.out_imm}, 64'h0000_0000_FFFF_FFFF);
      // B and J sign bit only.
      step(1'b1, 32'h8000_0000, 3'd2, 1'b1);
      check_val("b_sign", {32'd0, bus32.out_imm}, 64'h0000_0000_FFFF_F000);
      step(1'b1, 32'h8000_0000, 3'd3, 1'b1);
      check_val("j_sign", {32'd0, bus32.out_imm}, 64'h0000_0000_FFF0_0000);
      // U-type on the 64-bit instance.
      step(1'b1, 32'h8000_0000, 3'd4, 1'b1);
      check_val("u_64", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
      step(1'b0, 32'd0, 3'd0, 1'b1);

      // Backpressure: three back-to-back offers with the sink stalled.
      for (int i = 0; i < 3; i++) step(1'b1, $urandom, 3'($urandom_range(0, 5)), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, $urandom, 3'd0, 1'b1);

      // Simultaneous accept and drain for ten cycles.
      step(1'b1, $urandom, 3'd1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, $urandom, 3'($urandom_range(0, 5)), 1'b1);
      step(1'b0, 32'd0, 3'd0, 1'b1);

      // Illegal encodings, enough to saturate the counter.
      for (int i = 0; i < 300; i++) step(1'b1, $urandom, 3'd6, 1'b1);
      step(1'b0, 32'd0, 3'd0, 1'b1);
      check_val("cnt_sat", {56'd0, cnt32}, 64'd255);

      // Reset while full.
      for (int i = 0; i < 3; i++) step(1'b1, $urandom, 3'd7, 1'b0);
      apply_reset();
      step(1'b0, 32'd0, 3'd0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 3'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
